// File: rtl/arb_pkg.sv
// Shared types and one-hot helpers for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int ARB_N  = 4;
    localparam int ARB_DW = 8;
    // Helpers work on a fixed wide vector; callers zero-extend their N-bit one-hots.
    localparam int MAXN   = 64;

    function automatic int unsigned onehot_to_idx(input logic [MAXN-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAXN; i++) begin
            if (v[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

    function automatic logic [MAXN-1:0] width_mask(input int unsigned n);
        logic [MAXN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MAXN-1:0] oh_rotl1(input logic [MAXN-1:0] v, input int unsigned n);
        return ((v << 1) | (v >> (n - 1))) & width_mask(n);
    endfunction

    function automatic logic [MAXN-1:0] oh_rotr1(input logic [MAXN-1:0] v, input int unsigned n);
        return ((v >> 1) | (v << (n - 1))) & width_mask(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first unmasked request at or after
// the position following the one-hot 'last' pointer, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    input  logic [N-1:0] mask,
    output logic [N-1:0] pick,
    output logic         any
);

    logic [N-1:0]    cand;
    logic [N-1:0]    rot;
    logic [N-1:0]    low;
    logic [MAXN-1:0] start_oh;
    int unsigned     start_idx;

    assign cand      = req & ~mask;
    assign start_oh  = oh_rotl1(MAXN'(last), N);
    assign start_idx = onehot_to_idx(start_oh);

    // Rotate so the scan start sits at bit 0, isolate lowest set bit, rotate back.
    assign rot  = N'({cand, cand} >> start_idx);
    assign low  = rot & (-rot);
    assign pick = N'(({low, low} << start_idx) >> N);
    assign any  = |cand;

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant driving an AND-OR data mux.
// Optional ownership hold timeout enabled by defining ARB_HOLD_TIMEOUT_EN.
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int DW = ARB_DW
`ifdef ARB_HOLD_TIMEOUT_EN
    , parameter int MAX_HOLD = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      din,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [DW-1:0]        dout,
    output logic                 dout_valid
);

    localparam int IW = $clog2(N);

    arb_state_t    state, state_n;
    logic [N-1:0]  last, last_n, grant_n, pick, mask;
    logic          any, owner_drop, timeout, rearb;
    logic [DW-1:0] mux_sel;

    assign mask       = (state == OWNED) ? grant : '0;
    assign owner_drop = (state == OWNED) && ((req & grant) == '0);
    assign rearb      = (state == IDLE) || owner_drop || timeout;

    rr_pick #(.N(N)) u_pick (
        .req  (req),
        .last (last),
        .mask (mask),
        .pick (pick),
        .any  (any)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_cnt;
    logic          others;

    assign others  = |(req & ~grant);
    assign timeout = (state == OWNED) && (hold_cnt == HW'(MAX_HOLD - 1)) && others;

    // Saturates at MAX_HOLD-1 while nobody else is waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (rearb) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HW'(MAX_HOLD - 1)) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any) state_n = OWNED;
            OWNED:   if (rearb && !any) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        grant_n = grant;
        last_n  = last;
        if (rearb) begin
            grant_n = any ? pick : '0;
            if (any) last_n = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant     <= '0;
            grant_idx <= '0;
            last      <= {1'b1, {(N-1){1'b0}}};
        end else begin
            grant     <= grant_n;
            grant_idx <= IW'(onehot_to_idx(MAXN'(grant_n)));
            last      <= last_n;
        end
    end

    // ---- output stage: parallel AND-OR mux on the registered one-hot grant ----
    always_comb begin
        mux_sel = '0;
        for (int i = 0; i < N; i++) begin
            mux_sel = mux_sel | (din[i*DW +: DW] & {DW{grant[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= |grant;
            if (|grant) dout <= mux_sel;
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: directed vector table, hold-timeout
// sequence and a randomised run, all scored against a cycle model.
module tb_onehot_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic [7:0]  dout;
    logic        dout_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_rr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    typedef struct {
        logic [3:0] g;
        logic [1:0] gi;
        logic [7:0] d;
        logic       v;
    } exp_t;

    typedef struct {
        logic        r;
        logic [3:0]  q;
        logic [31:0] d;
        logic [3:0]  eg;
        logic        ev;
        logic [7:0]  ed;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[24];

    logic [3:0] m_grant = '0;
    logic [3:0] m_last  = 4'b1000;
    logic [7:0] m_dout  = '0;
    logic       m_valid = 1'b0;
    int         m_cnt   = 0;

    function automatic int tb_idx(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] q, input logic [31:0] d);
        logic [3:0] pick;
        logic       owned, rearb;
        int         li, j;
        if (!r) begin
            m_grant = '0; m_last = 4'b1000; m_cnt = 0; m_dout = '0; m_valid = 1'b0;
        end else begin
            owned = (m_grant != 4'b0);
            if (owned) m_dout = d[tb_idx(m_grant)*8 +: 8];
            m_valid = owned;
            rearb = !owned || ((q & m_grant) == 4'b0);
`ifdef ARB_HOLD_TIMEOUT_EN
            if (owned && m_cnt == 15 && (q & ~m_grant) != 4'b0) rearb = 1'b1;
`endif
            if (rearb) begin
                pick = '0;
                li = tb_idx(m_last);
                for (int k = 1; k <= 4; k++) begin
                    j = (li + k) % 4;
                    if (pick == 4'b0 && q[j] && !(owned && m_grant[j])) pick[j] = 1'b1;
                end
                m_grant = pick;
                if (pick != 4'b0) m_last = pick;
                m_cnt = 0;
            end else if (m_cnt != 15) begin
                m_cnt++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] q, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        rst_n = r; req = q; din = d;
        model_step(r, q, d);
        sbq.push_back('{m_grant, 2'(tb_idx(m_grant)), m_dout, m_valid});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_idx", 32'(grant_idx), 32'(e.gi));
        chk("dout_valid", 32'(dout_valid), 32'(e.v));
        chk("dout", 32'(dout), 32'(e.d));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        chk("grant_in_req", 32'((grant & ~q) == 4'b0), 32'd1);
    endtask

    initial begin
        logic [31:0] d1, d2;
        logic [3:0]  rq, eg;
        d1 = 32'h44332211;
        d2 = 32'h00A50000;
        vecs[0]  = '{1'b0, 4'h0, d1, 4'h0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 4'hF, d1, 4'h1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 4'hE, d1, 4'h2, 1'b1, 8'h11};
        vecs[3]  = '{1'b1, 4'hC, d1, 4'h4, 1'b1, 8'h22};
        vecs[4]  = '{1'b1, 4'h8, d1, 4'h8, 1'b1, 8'h33};
        vecs[5]  = '{1'b1, 4'h1, d1, 4'h1, 1'b1, 8'h44};
        vecs[6]  = '{1'b1, 4'h0, d1, 4'h0, 1'b1, 8'h11};
        vecs[7]  = '{1'b1, 4'h0, d1, 4'h0, 1'b0, 8'h11};
        vecs[8]  = '{1'b1, 4'h4, d2, 4'h4, 1'b0, 8'h11};
        vecs[9]  = '{1'b1, 4'h4, d2, 4'h4, 1'b1, 8'hA5};
        vecs[10] = '{1'b1, 4'h0, d2, 4'h0, 1'b1, 8'hA5};
        vecs[11] = '{1'b1, 4'h0, d2, 4'h0, 1'b0, 8'hA5};
        vecs[12] = '{1'b1, 4'h1, d1, 4'h1, 1'b0, 8'hA5};
        vecs[13] = '{1'b1, 4'h1, d1, 4'h1, 1'b1, 8'h11};
        vecs[14] = '{1'b1, 4'hA, d1, 4'h2, 1'b1, 8'h11};
        vecs[15] = '{1'b1, 4'hB, d1, 4'h2, 1'b1, 8'h22};
        vecs[16] = '{1'b1, 4'h0, d1, 4'h0, 1'b1, 8'h22};
        vecs[17] = '{1'b1, 4'h4, d1, 4'h4, 1'b0, 8'h22};
        vecs[18] = '{1'b1, 4'h4, d1, 4'h4, 1'b1, 8'h33};
        vecs[19] = '{1'b0, 4'h4, d1, 4'h0, 1'b0, 8'h00};
        vecs[20] = '{1'b1, 4'hF, d1, 4'h1, 1'b0, 8'h00};
        vecs[21] = '{1'b1, 4'hF, d1, 4'h1, 1'b1, 8'h11};
        vecs[22] = '{1'b1, 4'h0, d1, 4'h0, 1'b1, 8'h11};
        vecs[23] = '{1'b1, 4'h0, d1, 4'h0, 1'b0, 8'h11};

        for (int i = 0; i < 24; i++) begin
            cyc(vecs[i].r, vecs[i].q, vecs[i].d);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].ed));
        end

        // Two requesters held continuously: hold timeout alternates ownership.
        cyc(1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 64; c++) begin
            cyc(1'b1, 4'b0011, $urandom);
`ifdef ARB_HOLD_TIMEOUT_EN
            eg = (((c / 16) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            eg = 4'b0001;
`endif
            chk($sformatf("hold%0d", c), 32'(grant), 32'(eg));
        end

        rq = '0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            cyc(($urandom_range(0, 199) != 0), rq, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
